// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Zero-latency fetch lookup, trained by ID-stage resolution events.
module branch_target_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  localparam int IDX_W  = $clog2(ENTRIES),
  parameter int CNT_W   = 16
) (
  input  logic              CLK_IN,
  input  logic              GLOBALRESET,
  input  logic [ADDR_W-1:0] lookup_pc_in,
  output logic              hit_out,
  output logic              predict_taken_out,
  output logic [ADDR_W-1:0] predict_target_out,
  input  logic              update_valid_in,
  input  logic [ADDR_W-1:0] update_pc_in,
  input  logic              update_taken_in,
  input  logic [ADDR_W-1:0] update_target_in,
  input  logic              update_is_jump_in,
  input  logic              update_mispredict_in,
  input  logic              invalidate_all_in,
  output logic [CNT_W-1:0]  update_count_out,
  output logic [CNT_W-1:0]  mispredict_count_out
);

  localparam int TAG_W = ADDR_W - IDX_W - 2;

  if ((ENTRIES < 2) || ((ENTRIES & (ENTRIES - 1)) != 0)) begin : g_bad_entries
    $error("ENTRIES must be a power of two and at least 2");
  end

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tags    [ENTRIES];
  logic [ADDR_W-1:0]  targets [ENTRIES];
  logic [1:0]         ctrs    [ENTRIES];

  logic [IDX_W-1:0] l_idx;
  logic [TAG_W-1:0] l_tag;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic [1:0]       ctr_cur;
  logic [1:0]       ctr_nxt;
  logic             wr_entry;
  logic             wr_target;

  assign l_idx = lookup_pc_in[IDX_W+1:2];
  assign l_tag = lookup_pc_in[ADDR_W-1:IDX_W+2];
  assign u_idx = update_pc_in[IDX_W+1:2];
  assign u_tag = update_pc_in[ADDR_W-1:IDX_W+2];

  // Instruction alignment bits never take part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^update_pc_in[1:0];

  assign hit_out            = valid[l_idx] & (tags[l_idx] == l_tag);
  assign predict_taken_out  = hit_out & ctrs[l_idx][1];
  assign predict_target_out = predict_taken_out ? targets[l_idx]
                                                : lookup_pc_in + ADDR_W'(4);

  assign u_hit   = valid[u_idx] & (tags[u_idx] == u_tag);
  assign ctr_cur = ctrs[u_idx];

  assign wr_entry  = update_valid_in & ~invalidate_all_in
                   & (u_hit | update_taken_in);
  assign wr_target = update_taken_in | update_is_jump_in;

  always_comb begin
    ctr_nxt = 2'b10;
    if (update_is_jump_in) begin
      ctr_nxt = 2'b11;
    end else if (!u_hit) begin
      ctr_nxt = 2'b10;
    end else if (update_taken_in) begin
      ctr_nxt = (ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'd1;
    end else begin
      ctr_nxt = (ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'd1;
    end
  end

  always_ff @(posedge CLK_IN or negedge GLOBALRESET) begin
    if (!GLOBALRESET) begin
      valid <= '0;
    end else if (invalidate_all_in) begin
      valid <= '0;
    end else if (wr_entry) begin
      valid[u_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: an entry is only visible once its valid bit is set.
  always_ff @(posedge CLK_IN) begin
    if (wr_entry) begin
      tags[u_idx] <= u_tag;
      ctrs[u_idx] <= ctr_nxt;
      if (wr_target) begin
        targets[u_idx] <= update_target_in;
      end
    end
  end

  always_ff @(posedge CLK_IN or negedge GLOBALRESET) begin
    if (!GLOBALRESET) begin
      update_count_out     <= '0;
      mispredict_count_out <= '0;
    end else begin
      if (update_valid_in && (update_count_out != '1)) begin
        update_count_out <= update_count_out + 1'b1;
      end
      if (update_valid_in && update_mispredict_in
          && (mispredict_count_out != '1)) begin
        mispredict_count_out <= mispredict_count_out + 1'b1;
      end
    end
  end

endmodule
